uart_rx_os16: RTL and testbench

//  Oversampling UART receiver: the receive end of the 8N1-style serial link driven by the transmitter.

---
 rtl/uart_rx_os16.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_os16.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: oversampling UART receiver.
// The serial line is synchronised and sampled on baud_tick cycles only. Each bit
// is taken as the 2-of-3 vote of the samples around mid-bit. Received frames go
// into a valid/ready holding register together with their error flags.
//
// state  | meaning
// IDLE   | line idle; waits for synchronised rx=0 (or for rx=1 after a break)
// START  | start bit; a mid-bit vote of 1 is a false start
// DATA   | data bits shifted in LSB first
// PARITY | optional parity bit checked against the data
// STOP   | stop bit; the frame completes at mid-bit
module uart_rx_os16 #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] T_S0  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S1  = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_S2  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic                 rx_m, rx_s;
  logic [1:0]           smp;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bad;
  logic                 wait_high;
  logic                 vote;
  logic                 mid_tick;
  logic                 end_tick;
  logic                 complete;
  logic                 accept;
  logic                 brk;

  assign vote     = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
  assign mid_tick = baud_tick && (tick_cnt == T_S2);
  assign end_tick = baud_tick && (tick_cnt == T_END);
  assign complete = (state == STOP) && mid_tick;
  assign accept   = rx_valid & rx_ready;
  assign brk      = ~vote & (shift_reg == '0);

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Capture the first two of the three mid-bit samples; the third is rx_s itself at the vote tick.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      smp <= 2'b00;
    end else if (baud_tick && state != IDLE) begin
      if (tick_cnt == T_S0) smp[0] <= rx_s;
      if (tick_cnt == T_S1) smp[1] <= rx_s;
    end
  end

  // Frame sequencer plus the holding register and its handshake.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_bad    <= 1'b0;
      wait_high  <= 1'b0;
      data_out   <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (baud_tick) begin
        case (state)
          IDLE: begin
            if (wait_high) begin
              if (rx_s) wait_high <= 1'b0;
            end else if (!rx_s) begin
              state    <= START;
              tick_cnt <= '0;
              par_bad  <= 1'b0;
            end
          end
          START: begin
            tick_cnt <= tick_cnt + TW'(1);
            if (mid_tick && vote) begin
              state    <= IDLE;
              tick_cnt <= '0;
            end else if (end_tick) begin
              state    <= DATA;
              tick_cnt <= '0;
              bit_cnt  <= '0;
            end
          end
          DATA: begin
            tick_cnt <= tick_cnt + TW'(1);
            if (mid_tick) shift_reg <= DATA_BITS'({vote, shift_reg} >> 1);
            if (end_tick) begin
              tick_cnt <= '0;
              if (bit_cnt == B_LAST) state <= (PARITY_EN != 0) ? PARITY : STOP;
              else bit_cnt <= bit_cnt + BW'(1);
            end
          end
          PARITY: begin
            tick_cnt <= tick_cnt + TW'(1);
            if (mid_tick) par_bad <= vote ^ (^shift_reg) ^ ODD;
            if (end_tick) begin
              state    <= STOP;
              tick_cnt <= '0;
            end
          end
          STOP: begin
            tick_cnt <= tick_cnt + TW'(1);
            if (mid_tick) begin
              state     <= IDLE;
              tick_cnt  <= '0;
              wait_high <= brk;
            end
          end
          default: begin
            state    <= IDLE;
            tick_cnt <= '0;
          end
        endcase
      end

      // A full register that is not being drained drops the new frame.
      if (complete && rx_valid && !rx_ready) begin
        overrun <= 1'b1;
      end else if (complete) begin
        data_out   <= shift_reg;
        parity_err <= par_bad;
        frame_err  <= ~vote;
        break_det  <= brk;
        rx_valid   <= 1'b1;
        overrun    <= 1'b0;
      end else if (accept) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
`timescale 1ns/1ps
module tb_uart_rx_os16;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       brk;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic [7:0] e_d;
    logic       e_fe;
    logic       e_brk;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       pbit;
    logic       e_pe;
  } pvec_t;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic       rx_p = 1'b1;
  logic       rdy_p = 1'b1;
  logic       tick_en = 1'b0;
  int         div = 0;

  logic [7:0] data_out, data_p;
  logic       rx_valid, parity_err, frame_err, break_det, overrun;
  logic       valid_p, perr_p, ferr_p, brk_p, ovr_p;

  exp_t       sb_q[$];
  exp_t       sb_p[$];
  int         n_checks = 0;
  int         n_fail = 0;

  uart_rx_os16 dut (
    .sys_clk(sys_clk), .rst(rst), .baud_tick(baud_tick), .rx(rx), .rx_ready(rx_ready),
    .data_out(data_out), .rx_valid(rx_valid), .parity_err(parity_err),
    .frame_err(frame_err), .break_det(break_det), .overrun(overrun)
  );

  uart_rx_os16 #(.PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .sys_clk(sys_clk), .rst(rst), .baud_tick(baud_tick), .rx(rx_p), .rx_ready(rdy_p),
    .data_out(data_p), .rx_valid(valid_p), .parity_err(perr_p),
    .frame_err(ferr_p), .break_det(brk_p), .overrun(ovr_p)
  );

  always #5 sys_clk = ~sys_clk;

  // one baud_tick every 4 clocks, driven away from the active edge
  always @(negedge sys_clk) begin
    if (tick_en) begin
      div = (div == 3) ? 0 : div + 1;
      baud_tick = (div == 0);
    end else begin
      baud_tick = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic hold_ticks(input int n);
    repeat (n) begin
      do @(posedge sys_clk); while (!baud_tick);
    end
    @(negedge sys_clk);
  endtask

  task automatic drive(input logic v, input logic to_p);
    if (to_p) rx_p = v;
    else rx = v;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                            input logic stop, input logic to_p);
    drive(1'b0, to_p);
    hold_ticks(16);
    for (int i = 0; i < 8; i++) begin
      drive(d[i], to_p);
      hold_ticks(16);
    end
    if (par_en) begin
      drive(par_bit, to_p);
      hold_ticks(16);
    end
    drive(stop, to_p);
    hold_ticks(16);
    drive(1'b1, to_p);
    hold_ticks(8);
  endtask

  // scoreboard: every accepted byte must match the oldest pending expectation
  always @(negedge sys_clk) begin
    if (!rst && rx_valid && rx_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_byte", {24'h0, data_out}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_data", {24'h0, data_out}, {24'h0, e.d});
        check("sb_parity_err", {31'h0, parity_err}, {31'h0, e.pe});
        check("sb_frame_err", {31'h0, frame_err}, {31'h0, e.fe});
        check("sb_break", {31'h0, break_det}, {31'h0, e.brk});
      end
    end
  end

  always @(negedge sys_clk) begin
    if (!rst && valid_p && rdy_p) begin
      if (sb_p.size() == 0) begin
        check("unexpected_byte_p", {24'h0, data_p}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_p.pop_front();
        check("sbp_data", {24'h0, data_p}, {24'h0, e.d});
        check("sbp_parity_err", {31'h0, perr_p}, {31'h0, e.pe});
        check("sbp_frame_err", {31'h0, ferr_p}, {31'h0, e.fe});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t  tv[6];
    pvec_t pv[4];
    tv[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0, 1'b0};
    tv[1] = '{8'h3C, 1'b1, 8'h3C, 1'b0, 1'b0};
    tv[2] = '{8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0};
    tv[3] = '{8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    tv[4] = '{8'h5A, 1'b0, 8'h5A, 1'b1, 1'b0};
    tv[5] = '{8'h81, 1'b1, 8'h81, 1'b0, 1'b0};
    pv[0] = '{8'h07, 1'b0, 1'b1};
    pv[1] = '{8'h07, 1'b1, 1'b0};
    pv[2] = '{8'hA5, 1'b0, 1'b0};
    pv[3] = '{8'hA5, 1'b1, 1'b1};

    rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_data", {24'h0, data_out}, 32'h0);
    check("rst_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_flags", {29'h0, parity_err, frame_err, break_det}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    @(negedge sys_clk);
    rst = 1'b0;
    tick_en = 1'b1;
    hold_ticks(20);

    // A5 with exact output latency
    rx_ready = 1'b1;
    sb_q.push_back('{8'hA5, 1'b0, 1'b0, 1'b0});
    drive(1'b0, 1'b0);
    hold_ticks(16);
    for (int i = 0; i < 8; i++) begin
      drive(((8'hA5 >> i) & 8'h01) != 0, 1'b0);
      hold_ticks(16);
    end
    drive(1'b1, 1'b0);
    hold_ticks(10);
    check("lat_before_tick9", {31'h0, rx_valid}, 32'h0);
    hold_ticks(1);
    check("lat_after_tick9", {31'h0, rx_valid}, 32'h1);
    @(negedge sys_clk);
    check("valid_one_cycle", {31'h0, rx_valid}, 32'h0);
    hold_ticks(5);
    hold_ticks(8);

    for (int i = 0; i < 6; i++) begin
      sb_q.push_back('{tv[i].e_d, 1'b0, tv[i].e_fe, tv[i].e_brk});
      send_frame(tv[i].d, 1'b0, 1'b0, tv[i].stop, 1'b0);
    end

    // false start: 4 ticks low
    drive(1'b0, 1'b0);
    hold_ticks(4);
    drive(1'b1, 1'b0);
    hold_ticks(40);
    check("glitch_no_valid", {31'h0, rx_valid}, 32'h0);
    sb_q.push_back('{8'h3C, 1'b0, 1'b0, 1'b0});
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);

    // one-tick high glitch on the centre sample of data bit 2 of 00
    sb_q.push_back('{8'h00, 1'b0, 1'b0, 1'b0});
    drive(1'b0, 1'b0);
    hold_ticks(16);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        hold_ticks(9);
        drive(1'b1, 1'b0);
        hold_ticks(1);
        drive(1'b0, 1'b0);
        hold_ticks(6);
      end else begin
        hold_ticks(16);
      end
    end
    drive(1'b1, 1'b0);
    hold_ticks(24);

    // even parity receiver
    for (int i = 0; i < 4; i++) begin
      sb_p.push_back('{pv[i].d, pv[i].e_pe, 1'b0, 1'b0});
      send_frame(pv[i].d, 1'b1, pv[i].pbit, 1'b1, 1'b1);
    end

    // overrun: second frame dropped while register is full
    rx_ready = 1'b0;
    sb_q.push_back('{8'h11, 1'b0, 1'b0, 1'b0});
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ovr_data_kept", {24'h0, data_out}, 32'h11);
    check("ovr_valid", {31'h0, rx_valid}, 32'h1);
    check("ovr_set", {31'h0, overrun}, 32'h1);
    @(posedge sys_clk);
    #1 rx_ready = 1'b1;
    @(posedge sys_clk);
    #1 rx_ready = 1'b0;
    check("ovr_accept_valid", {31'h0, rx_valid}, 32'h0);
    check("ovr_accept_clear", {31'h0, overrun}, 32'h0);

    // break: 12 bit times low, then no frame until the line goes high
    hold_ticks(2);
    rx_ready = 1'b1;
    sb_q.push_back('{8'h00, 1'b0, 1'b1, 1'b1});
    drive(1'b0, 1'b0);
    hold_ticks(192);
    check("break_reported", sb_q.size(), 32'h0);
    check("break_no_refire", {31'h0, rx_valid}, 32'h0);
    drive(1'b1, 1'b0);
    hold_ticks(20);
    sb_q.push_back('{8'h5A, 1'b0, 1'b0, 1'b0});
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);

    // reset mid-frame with a full register and overrun pending
    rx_ready = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    check("pre_rst_data", {24'h0, data_out}, 32'h5A);
    check("pre_rst_fe", {31'h0, frame_err}, 32'h1);
    check("pre_rst_ovr", {31'h0, overrun}, 32'h1);
    drive(1'b0, 1'b0);
    hold_ticks(16);
    for (int i = 0; i < 3; i++) begin
      drive(i[0], 1'b0);
      hold_ticks(16);
    end
    hold_ticks(5);
    rst = 1'b1;
    #1;
    check("rst_mid_data", {24'h0, data_out}, 32'h0);
    check("rst_mid_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_mid_flags", {29'h0, parity_err, frame_err, break_det}, 32'h0);
    check("rst_mid_overrun", {31'h0, overrun}, 32'h0);
    repeat (3) @(negedge sys_clk);
    drive(1'b1, 1'b0);
    rst = 1'b0;
    rx_ready = 1'b1;
    hold_ticks(30);
    sb_q.push_back('{8'h3C, 1'b0, 1'b0, 1'b0});
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);

    hold_ticks(10);
    check("sb_drained", sb_q.size(), 32'h0);
    check("sbp_drained", sb_p.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
